// File: rtl/fetch_execute_seq.sv
// rtl/fetch_execute_seq.sv - PATP fetch/execute sequencer driving the phase flag; optional single-step build via FE_SINGLE_STEP_EN
module fetch_execute_seq #(
    parameter int MEM_TIMEOUT = 8,
    parameter int STEP_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              halt_req,
    input  logic              mem_ack,
    input  logic              exec_done,
    input  logic              fe_q,
`ifdef FE_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              trigger_set,
    output logic              trigger_rst,
    output logic              mem_rd,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              exec_start,
    output logic [STEP_W-1:0] t_step,
    output logic              halted,
    output logic              fault
);

    // Timeout counter only has to reach MEM_TIMEOUT-1 (index of the last allowed FETCH cycle).
    localparam int               CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

`ifdef FE_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_EXEC_WAIT, S_HALT, S_FAULT, S_PAUSE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_EXEC_WAIT, S_HALT, S_FAULT
    } state_t;
`endif

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   to_cnt;
    logic [CNT_W-1:0]   to_cnt_d;
    logic               trig_set_d;
    logic               trig_rst_d;
    logic               fetch_done_d;
    logic               exec_start_d;
    logic               mem_rd_d;
    logic               halted_d;
    logic               fault_d;
    logic [STEP_W-1:0]  t_step_d;
    logic               quiet_d;

`ifdef FE_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;

    // Remember last step level so a held step button only advances once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step & ~step_q;
`endif

    // Next state and next-cycle output values; outputs are registered so they line up with the state entered.
    always_comb begin
        state_d      = state;
        to_cnt_d     = '0;
        trig_set_d   = 1'b0;
        trig_rst_d   = 1'b0;
        fetch_done_d = 1'b0;
        exec_start_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_d    = S_FETCH;
                    trig_rst_d = 1'b1;
                end
            end
            S_FETCH: begin
                // First FETCH cycle still sees the flag before trigger_rst lands, so skip it.
                if (fe_q && (to_cnt != '0)) begin
                    state_d = S_FAULT;
                end else if (mem_ack) begin
                    state_d      = S_DECODE;
                    fetch_done_d = 1'b1;
                    trig_set_d   = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                if (halt_req) begin
                    state_d    = S_HALT;
                    trig_rst_d = 1'b1;
                end else begin
                    state_d      = S_EXEC;
                    exec_start_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d = fe_q ? S_EXEC_WAIT : S_FAULT;
            end
            S_EXEC_WAIT: begin
                if (!fe_q) begin
                    state_d = S_FAULT;
                end else if (exec_done) begin
                    trig_rst_d = 1'b1;
`ifdef FE_SINGLE_STEP_EN
                    state_d    = run ? S_PAUSE : S_IDLE;
`else
                    state_d    = run ? S_FETCH : S_IDLE;
`endif
                end
            end
            S_HALT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
`ifdef FE_SINGLE_STEP_EN
            S_PAUSE: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (step_rise) begin
                    state_d    = S_FETCH;
                    trig_rst_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_FAULT;
            end
        endcase

        mem_rd_d = (state_d == S_FETCH);
        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_FAULT);

        quiet_d = (state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_FAULT);
`ifdef FE_SINGLE_STEP_EN
        quiet_d = quiet_d || (state_d == S_PAUSE);
`endif
        if (quiet_d || trig_set_d || trig_rst_d) begin
            t_step_d = '0;
        end else if (t_step == '1) begin
            t_step_d = t_step;
        end else begin
            t_step_d = t_step + 1'b1;
        end
    end

    // State, timeout counter and all registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            to_cnt      <= '0;
            trigger_set <= 1'b0;
            trigger_rst <= 1'b0;
            mem_rd      <= 1'b0;
            ir_load     <= 1'b0;
            pc_inc      <= 1'b0;
            exec_start  <= 1'b0;
            t_step      <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_d;
            to_cnt      <= to_cnt_d;
            trigger_set <= trig_set_d;
            trigger_rst <= trig_rst_d;
            mem_rd      <= mem_rd_d;
            ir_load     <= fetch_done_d;
            pc_inc      <= fetch_done_d;
            exec_start  <= exec_start_d;
            t_step      <= t_step_d;
            halted      <= halted_d;
            fault       <= fault_d;
        end
    end

endmodule
